uart_tx_pacote: RTL and testbench



---
 rtl/uart_tx_pacote.sv | 184 ++++++++++++++++++
 tb/tb_uart_tx_pacote.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_pacote.sv
// uart_tx_pacote
// Two-byte UART packet transmitter (FPGA -> PC). On a start request while
// idle it latches a code byte and a data byte and sends them back-to-back as
// two frames on the TX line: code first, data second, with no idle gap
// between the frames.
//
// Optional feature macro: UART_TX_PACOTE_PARITY_EN
//   defined   -> 8E1 frames (even parity bit after bit 7), F = 11*CLKS_PER_BIT
//   undefined -> 8N1 frames, F = 10*CLKS_PER_BIT
//
// Parameters:
//   CLKS_PER_BIT       clock cycles per UART bit (>= 2)
// Ports:
//   clock              system clock, rising edge
//   reset              asynchronous, active-high reset
//   iniciarEnvio       start request, sampled only while idle
//   byteCodigo[7:0]    first byte sent (response code)
//   byteDado[7:0]      second byte sent (payload)
//   bitSerialAtualTX   serial line to PC, idles high (registered)
//   indicaTransmissao  high while a packet is in flight (registered)
//   pacoteEnviado      one-cycle pulse after the second stop bit (registered)

module uart_tx_pacote #(
   parameter int CLKS_PER_BIT = 5208
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       iniciarEnvio,
   input  logic [7:0] byteCodigo,
   input  logic [7:0] byteDado,
   output logic       bitSerialAtualTX,
   output logic       indicaTransmissao,
   output logic       pacoteEnviado
);

   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
`ifdef UART_TX_PACOTE_PARITY_EN
      S_PARITY,
`endif
      S_STOP
   } state_t;

   state_t          state_reg, state_next;
   logic [CW-1:0]   cnt_reg, cnt_next;
   logic [2:0]      bit_reg, bit_next;
   logic            byte_idx_reg, byte_idx_next;
   logic [7:0]      code_reg, code_next;
   logic [7:0]      data_reg, data_next;
   logic            tx_reg, tx_next;
   logic            busy_reg, busy_next;
   logic            done_reg, done_next;
   logic            cnt_end;
   logic [7:0]      cur_byte;

   assign cnt_end = (cnt_reg == CNT_MAX);

   // State register, plus the registered copies of the outputs.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_reg    <= S_IDLE;
         cnt_reg      <= '0;
         bit_reg      <= '0;
         byte_idx_reg <= 1'b0;
         code_reg     <= '0;
         data_reg     <= '0;
         tx_reg       <= 1'b1;
         busy_reg     <= 1'b0;
         done_reg     <= 1'b0;
      end else begin
         state_reg    <= state_next;
         cnt_reg      <= cnt_next;
         bit_reg      <= bit_next;
         byte_idx_reg <= byte_idx_next;
         code_reg     <= code_next;
         data_reg     <= data_next;
         tx_reg       <= tx_next;
         busy_reg     <= busy_next;
         done_reg     <= done_next;
      end
   end

   // Next-state logic.
   always_comb begin
      state_next    = state_reg;
      cnt_next      = cnt_reg;
      bit_next      = bit_reg;
      byte_idx_next = byte_idx_reg;
      code_next     = code_reg;
      data_next     = data_reg;
      case (state_reg)
         S_IDLE: begin
            cnt_next = '0;
            bit_next = '0;
            if (iniciarEnvio) begin
               code_next     = byteCodigo;
               data_next     = byteDado;
               byte_idx_next = 1'b0;
               state_next    = S_START;
            end
         end
         S_START: begin
            if (cnt_end) begin
               cnt_next   = '0;
               bit_next   = '0;
               state_next = S_DATA;
            end else begin
               cnt_next = cnt_reg + CW'(1);
            end
         end
         S_DATA: begin
            if (cnt_end) begin
               cnt_next = '0;
               if (bit_reg == 3'd7) begin
`ifdef UART_TX_PACOTE_PARITY_EN
                  state_next = S_PARITY;
`else
                  state_next = S_STOP;
`endif
               end else begin
                  bit_next = bit_reg + 3'd1;
               end
            end else begin
               cnt_next = cnt_reg + CW'(1);
            end
         end
`ifdef UART_TX_PACOTE_PARITY_EN
         S_PARITY: begin
            if (cnt_end) begin
               cnt_next   = '0;
               state_next = S_STOP;
            end else begin
               cnt_next = cnt_reg + CW'(1);
            end
         end
`endif
         S_STOP: begin
            if (cnt_end) begin
               cnt_next = '0;
               if (!byte_idx_reg) begin
                  // Second frame starts straight away, no idle gap.
                  byte_idx_next = 1'b1;
                  state_next    = S_START;
               end else begin
                  byte_idx_next = 1'b0;
                  state_next    = S_IDLE;
               end
            end else begin
               cnt_next = cnt_reg + CW'(1);
            end
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase
   end

   // Output logic. Outputs are decoded from the next state and registered,
   // so the line changes in the cycle right after the deciding edge.
   always_comb begin
      cur_byte  = byte_idx_next ? data_next : code_next;
      busy_next = (state_next != S_IDLE);
      done_next = (state_reg == S_STOP) && cnt_end && byte_idx_reg;
      tx_next   = 1'b1;
      case (state_next)
         S_START:  tx_next = 1'b0;
         S_DATA:   tx_next = cur_byte[bit_next];
`ifdef UART_TX_PACOTE_PARITY_EN
         S_PARITY: tx_next = ^cur_byte;
`endif
         default:  tx_next = 1'b1;
      endcase
   end

   assign bitSerialAtualTX  = tx_reg;
   assign indicaTransmissao = busy_reg;
   assign pacoteEnviado     = done_reg;

endmodule

// File: tb/tb_uart_tx_pacote.sv
// Testbench for uart_tx_pacote with CLKS_PER_BIT = 4. Expected per-cycle
// {tx, busy, done} triples are pushed to a queue when a packet is started
// and popped / compared once per cycle on the falling clock edge.
module tb_uart_tx_pacote;

   localparam int C = 4;
`ifdef UART_TX_PACOTE_PARITY_EN
   localparam int F = 11 * C;
`else
   localparam int F = 10 * C;
`endif

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       ini = 1'b0;
   logic [7:0] codigo = 8'h00;
   logic [7:0] dado = 8'h00;
   logic       tx, busy, done;

   logic [2:0] exp_q[$];
   int         tests_run = 0;
   int         tests_failed = 0;

   uart_tx_pacote #(.CLKS_PER_BIT(C)) dut (
      .clock             (clock),
      .reset             (reset),
      .iniciarEnvio      (ini),
      .byteCodigo        (codigo),
      .byteDado          (dado),
      .bitSerialAtualTX  (tx),
      .indicaTransmissao (busy),
      .pacoteEnviado     (done)
   );

   always #5 clock = ~clock;

   // Scoreboard model of one frame: start, 8 data bits LSB first,
   // optional even parity, stop.
   task automatic push_frame(input logic [7:0] b);
      for (int i = 0; i < C; i++) exp_q.push_back(3'b010);
      for (int k = 0; k < 8; k++)
         for (int i = 0; i < C; i++) exp_q.push_back({b[k], 2'b10});
`ifdef UART_TX_PACOTE_PARITY_EN
      for (int i = 0; i < C; i++) exp_q.push_back({^b, 2'b10});
`endif
      for (int i = 0; i < C; i++) exp_q.push_back(3'b110);
   endtask

   task automatic push_packet(input logic [7:0] c, input logic [7:0] d);
      push_frame(c);
      push_frame(d);
      exp_q.push_back(3'b101);   // idle cycle carrying the done pulse
   endtask

   task automatic test_reset();
      logic [2:0] obs;
      @(negedge clock);
      obs = {tx, busy, done};
      tests_run++;
      if (obs !== 3'b100) begin
         tests_failed++;
         $display("FAIL reset_held: tx/busy/done=%b expected 100", obs);
      end
      reset = 1'b0;
      for (int n = 0; n < 20; n++) begin
         @(negedge clock);
         obs = {tx, busy, done};
         tests_run++;
         if (obs !== 3'b100) begin
            tests_failed++;
            $display("FAIL reset_idle cyc %0d: tx/busy/done=%b expected 100", n, obs);
         end
      end
      $display("[TB] reset/idle checked");
   endtask

   // Sends one packet and checks every cycle. If pulse_at >= 0 a new start
   // with different bytes is pulsed at that cycle and must be ignored.
   task automatic test_packet(input logic [7:0] c, input logic [7:0] d, input int pulse_at);
      logic [2:0] obs, expv;
      int n;
      exp_q.delete();
      @(negedge clock);
      codigo = c;
      dado   = d;
      ini    = 1'b1;
      push_packet(c, d);
      repeat (6) exp_q.push_back(3'b100);
      n = 0;
      while (exp_q.size() > 0) begin
         @(negedge clock);
         obs  = {tx, busy, done};
         expv = exp_q.pop_front();
         tests_run++;
         if (obs !== expv) begin
            tests_failed++;
            $display("FAIL packet_%h_%h cyc %0d: tx/busy/done=%b expected %b", c, d, n + 1, obs, expv);
         end
         ini = (n == pulse_at);
         if (n == pulse_at) begin
            codigo = ~c;
            dado   = ~d;
         end
         n++;
      end
      ini = 1'b0;
      $display("[TB] packet code=%h data=%h pulse_at=%0d checked", c, d, pulse_at);
   endtask

   task automatic test_reset_mid();
      logic [2:0] obs, expv;
      exp_q.delete();
      @(negedge clock);
      codigo = 8'h3C;
      dado   = 8'h5A;
      ini    = 1'b1;
      push_packet(8'h3C, 8'h5A);
      // Run into byte 1, bit 3 (entry F + 4C is its first cycle).
      for (int n = 0; n <= F + 4 * C + 1; n++) begin
         @(negedge clock);
         ini  = 1'b0;
         obs  = {tx, busy, done};
         expv = exp_q.pop_front();
         tests_run++;
         if (obs !== expv) begin
            tests_failed++;
            $display("FAIL reset_mid_pre cyc %0d: tx/busy/done=%b expected %b", n + 1, obs, expv);
         end
      end
      exp_q.delete();
      #2 reset = 1'b1;
      #1 obs = {tx, busy, done};
      tests_run++;
      if (obs !== 3'b100) begin
         tests_failed++;
         $display("FAIL reset_mid_async: tx/busy/done=%b expected 100", obs);
      end
      @(negedge clock);
      reset = 1'b0;
      for (int n = 0; n < 8; n++) begin
         @(negedge clock);
         obs = {tx, busy, done};
         tests_run++;
         if (obs !== 3'b100) begin
            tests_failed++;
            $display("FAIL reset_mid_idle cyc %0d: tx/busy/done=%b expected 100", n, obs);
         end
      end
      $display("[TB] mid-frame reset checked");
      test_packet(8'hC3, 8'h81, -1);
   endtask

   task automatic test_back_to_back();
      logic [2:0] obs, expv;
      int n;
      exp_q.delete();
      @(negedge clock);
      codigo = 8'h96;
      dado   = 8'h1E;
      ini    = 1'b1;
      repeat (3) push_packet(8'h96, 8'h1E);
      repeat (6) exp_q.push_back(3'b100);
      n = 0;
      while (exp_q.size() > 0) begin
         @(negedge clock);
         obs  = {tx, busy, done};
         expv = exp_q.pop_front();
         tests_run++;
         if (obs !== expv) begin
            tests_failed++;
            $display("FAIL back_to_back cyc %0d: tx/busy/done=%b expected %b", n + 1, obs, expv);
         end
         if (n == 4 * F + 2) ini = 1'b0;   // third packet already accepted
         n++;
      end
      ini = 1'b0;
      $display("[TB] back-to-back 3 packets checked (starts at 1, %0d, %0d)", 2 * F + 2, 4 * F + 3);
   endtask

   initial begin
      test_reset();
      test_packet(8'h55, 8'hA3, -1);
      test_packet(8'h55, 8'hA3, 30);
      test_reset_mid();
      test_back_to_back();
`ifdef UART_TX_PACOTE_PARITY_EN
      test_packet(8'h07, 8'h03, -1);
`endif
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
